// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC operation
// encodings and the width of the operation select field.
package pc_sequencer_pkg;

    localparam int PC_SEL_W = 3;

    // Next-PC operations; encodings 5..7 are illegal and fall back to SEQ
    typedef enum logic [PC_SEL_W-1:0] {
        PCS_SEQ    = 3'd0,
        PCS_BRANCH = 3'd1,
        PCS_JUMP   = 3'd2,
        PCS_CALL   = 3'd3,
        PCS_RET    = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_ras_stack.sv
// Return-address stack: DEPTH x WIDTH LIFO. Reset clears only the entry
// count; stored addresses are left as they are since they are unreachable
// until rewritten by a push.
module pc_ras_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PUSH,
    input  logic             POP,
    input  logic [WIDTH-1:0] PUSH_DATA,
    output logic [WIDTH-1:0] TOP,
    output logic             EMPTY,
    output logic             FULL
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    top_ptr;

    assign wr_ptr  = count[AW-1:0];
    assign top_ptr = wr_ptr - AW'(1);
    assign TOP     = mem[top_ptr];
    assign EMPTY   = (count == '0);
    assign FULL    = (count == CW'(DEPTH));

    // Entry count: pushes into a full stack and pops from an empty one are ignored
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (PUSH && !FULL) begin
            count <= count + CW'(1);
        end else if (POP && !EMPTY) begin
            count <= count - CW'(1);
        end
    end

    // Storage write at the slot just above the current top
    always_ff @(posedge CLK) begin
        if (PUSH && !FULL) begin
            mem[wr_ptr] <= PUSH_DATA;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with stall, relative branch, absolute jump and
// call/return through an internal return-address stack. Errors (stack
// overflow, underflow, illegal op) are collected in a sticky flag.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STEP      = 1,
    parameter int RESET_VEC = 0,
    parameter int DEPTH     = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                STALL,
    input  logic [PC_SEL_W-1:0] PC_SEL,
    input  logic [WIDTH-1:0]    OFFSET,
    input  logic [WIDTH-1:0]    TARGET,
    output logic [WIDTH-1:0]    PC_OUT,
    output logic [WIDTH-1:0]    PC_NEXT,
    output logic                STACK_EMPTY,
    output logic                STACK_FULL,
    output logic                ERR
);

    localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VEC);

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;
    logic             err_set;

    assign seq_pc = PC_OUT + STEP_V;

    pc_ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RESET     (RESET),
        .PUSH      (ras_push),
        .POP       (ras_pop),
        .PUSH_DATA (seq_pc),
        .TOP       (ras_top),
        .EMPTY     (STACK_EMPTY),
        .FULL      (STACK_FULL)
    );

    // Next-PC selection plus the stack requests and error events it implies
    always_comb begin
        PC_NEXT  = seq_pc;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        err_set  = 1'b0;
        if (STALL) begin
            PC_NEXT = PC_OUT;
        end else begin
            case (PC_SEL)
                PCS_SEQ:    PC_NEXT = seq_pc;
                PCS_BRANCH: PC_NEXT = PC_OUT + OFFSET;
                PCS_JUMP:   PC_NEXT = TARGET;
                PCS_CALL: begin
                    PC_NEXT = TARGET;
                    if (STACK_FULL) begin
                        err_set = 1'b1;
                    end else begin
                        ras_push = 1'b1;
                    end
                end
                PCS_RET: begin
                    if (STACK_EMPTY) begin
                        err_set = 1'b1;
                    end else begin
                        PC_NEXT = ras_top;
                        ras_pop = 1'b1;
                    end
                end
                default: begin
                    PC_NEXT = seq_pc;
                    err_set = 1'b1;
                end
            endcase
        end
    end

    // PC register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PC_OUT <= RESET_V;
        end else begin
            PC_OUT <= PC_NEXT;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ERR <= 1'b0;
        end else if (err_set) begin
            ERR <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of vectors applied one per cycle, with the
// expected registered outputs queued when driven and compared after the edge.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int WIDTH = 8;

    typedef struct {
        logic             preReset;
        logic             stall;
        logic [2:0]       sel;
        logic [WIDTH-1:0] off;
        logic [WIDTH-1:0] tgt;
        logic [WIDTH-1:0] expNext;
        logic [WIDTH-1:0] expPc;
        logic             expEmpty;
        logic             expFull;
        logic             expErr;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] pc;
        logic             empty;
        logic             full;
        logic             err;
    } exp_t;

    logic             CLK;
    logic             RESET;
    logic             STALL;
    logic [2:0]       PC_SEL;
    logic [WIDTH-1:0] OFFSET;
    logic [WIDTH-1:0] TARGET;
    logic [WIDTH-1:0] PC_OUT;
    logic [WIDTH-1:0] PC_NEXT;
    logic             STACK_EMPTY;
    logic             STACK_FULL;
    logic             ERR;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    exp_t expQ[$];

    pc_sequencer #(
        .WIDTH     (WIDTH),
        .STEP      (1),
        .RESET_VEC (0),
        .DEPTH     (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .STALL       (STALL),
        .PC_SEL      (PC_SEL),
        .OFFSET      (OFFSET),
        .TARGET      (TARGET),
        .PC_OUT      (PC_OUT),
        .PC_NEXT     (PC_NEXT),
        .STACK_EMPTY (STACK_EMPTY),
        .STACK_FULL  (STACK_FULL),
        .ERR         (ERR)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not finish, required finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic pre, input logic stall, input logic [2:0] sel,
                          input logic [7:0] off, input logic [7:0] tgt,
                          input logic [7:0] nxt, input logic [7:0] pc,
                          input logic e, input logic f, input logic r);
        vec_t v;
        v.preReset = pre;  v.stall = stall; v.sel = sel;
        v.off = off;       v.tgt = tgt;     v.expNext = nxt;
        v.expPc = pc;      v.expEmpty = e;  v.expFull = f; v.expErr = r;
        vecs.push_back(v);
    endtask

    // Mid-cycle reset: outputs must clear without waiting for an edge
    task automatic pulseReset();
        STALL = 1'b1;
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        checkOutput("async_reset_pc", 32'(PC_OUT), 32'h0);
        checkOutput("async_reset_empty", 32'(STACK_EMPTY), 32'h1);
        checkOutput("async_reset_full", 32'(STACK_FULL), 32'h0);
        checkOutput("async_reset_err", 32'(ERR), 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge CLK);
        STALL  = v.stall;
        PC_SEL = v.sel;
        OFFSET = v.off;
        TARGET = v.tgt;
        #1;
        checkOutput($sformatf("v%0d_pc_next", idx), 32'(PC_NEXT), 32'(v.expNext));
        e.pc = v.expPc; e.empty = v.expEmpty; e.full = v.expFull; e.err = v.expErr;
        expQ.push_back(e);
        @(posedge CLK);
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL v%0d_scoreboard: got empty queue, expected an entry", idx);
        end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("v%0d_pc_out", idx), 32'(PC_OUT), 32'(e.pc));
            checkOutput($sformatf("v%0d_empty", idx), 32'(STACK_EMPTY), 32'(e.empty));
            checkOutput($sformatf("v%0d_full", idx), 32'(STACK_FULL), 32'(e.full));
            checkOutput($sformatf("v%0d_err", idx), 32'(ERR), 32'(e.err));
        end
    endtask

    initial begin
        RESET  = 1'b0;
        STALL  = 1'b0;
        PC_SEL = PCS_JUMP;
        OFFSET = 8'h00;
        TARGET = 8'h55;

        //      pre stall sel  off    tgt    next   pc     e  f  r
        addVec(0, 0, 3'd0, 8'h00, 8'h00, 8'h01, 8'h01, 1, 0, 0);
        addVec(0, 0, 3'd0, 8'h00, 8'h00, 8'h02, 8'h02, 1, 0, 0);
        addVec(0, 0, 3'd0, 8'h00, 8'h00, 8'h03, 8'h03, 1, 0, 0);
        addVec(0, 0, 3'd0, 8'h00, 8'h00, 8'h04, 8'h04, 1, 0, 0);
        addVec(0, 0, 3'd0, 8'h00, 8'h00, 8'h05, 8'h05, 1, 0, 0);
        addVec(1, 0, 3'd2, 8'h00, 8'h10, 8'h10, 8'h10, 1, 0, 0);
        addVec(0, 0, 3'd1, 8'hF8, 8'h00, 8'h08, 8'h08, 1, 0, 0);
        addVec(0, 0, 3'd2, 8'h00, 8'hFE, 8'hFE, 8'hFE, 1, 0, 0);
        addVec(0, 0, 3'd0, 8'h00, 8'h00, 8'hFF, 8'hFF, 1, 0, 0);
        addVec(0, 0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0);
        addVec(0, 0, 3'd2, 8'h00, 8'h05, 8'h05, 8'h05, 1, 0, 0);
        addVec(0, 0, 3'd3, 8'h00, 8'h40, 8'h40, 8'h40, 0, 0, 0);
        addVec(0, 0, 3'd4, 8'h00, 8'h00, 8'h06, 8'h06, 1, 0, 0);
        addVec(0, 0, 3'd3, 8'h00, 8'h20, 8'h20, 8'h20, 0, 0, 0);
        addVec(0, 0, 3'd3, 8'h00, 8'h21, 8'h21, 8'h21, 0, 0, 0);
        addVec(0, 0, 3'd3, 8'h00, 8'h22, 8'h22, 8'h22, 0, 0, 0);
        addVec(0, 0, 3'd3, 8'h00, 8'h23, 8'h23, 8'h23, 0, 1, 0);
        addVec(0, 0, 3'd3, 8'h00, 8'h24, 8'h24, 8'h24, 0, 1, 1);
        addVec(0, 0, 3'd4, 8'h00, 8'h00, 8'h23, 8'h23, 0, 0, 1);
        addVec(0, 0, 3'd4, 8'h00, 8'h00, 8'h22, 8'h22, 0, 0, 1);
        addVec(0, 0, 3'd4, 8'h00, 8'h00, 8'h21, 8'h21, 0, 0, 1);
        addVec(0, 0, 3'd4, 8'h00, 8'h00, 8'h07, 8'h07, 1, 0, 1);
        addVec(0, 0, 3'd4, 8'h00, 8'h00, 8'h08, 8'h08, 1, 0, 1);
        addVec(1, 0, 3'd2, 8'h00, 8'h10, 8'h10, 8'h10, 1, 0, 0);
        addVec(0, 1, 3'd2, 8'h00, 8'h80, 8'h10, 8'h10, 1, 0, 0);
        addVec(0, 1, 3'd7, 8'h00, 8'h80, 8'h10, 8'h10, 1, 0, 0);
        addVec(0, 1, 3'd2, 8'h00, 8'h80, 8'h10, 8'h10, 1, 0, 0);
        addVec(0, 0, 3'd2, 8'h00, 8'h80, 8'h80, 8'h80, 1, 0, 0);
        addVec(0, 1, 3'd3, 8'h00, 8'h55, 8'h80, 8'h80, 1, 0, 0);
        addVec(0, 0, 3'd2, 8'h00, 8'h30, 8'h30, 8'h30, 1, 0, 0);
        addVec(0, 0, 3'd6, 8'h00, 8'h00, 8'h31, 8'h31, 1, 0, 1);
        addVec(0, 0, 3'd0, 8'h00, 8'h00, 8'h32, 8'h32, 1, 0, 1);
        addVec(0, 1, 3'd5, 8'h00, 8'h00, 8'h32, 8'h32, 1, 0, 1);
        addVec(1, 0, 3'd0, 8'h00, 8'h00, 8'h01, 8'h01, 1, 0, 0);

        // Reset held across an edge with a live JUMP request: nothing moves
        @(posedge CLK);
        #1;
        checkOutput("reset_hold_pc", 32'(PC_OUT), 32'h0);
        checkOutput("reset_empty", 32'(STACK_EMPTY), 32'h1);
        checkOutput("reset_full", 32'(STACK_FULL), 32'h0);
        checkOutput("reset_err", 32'(ERR), 32'h0);
        STALL = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].preReset) begin
                pulseReset();
            end
            applyStimulus(vecs[i], i);
        end

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
